bin2bcd_disp: RTL and testbench

- Sequential binary-to-BCD converter that feeds the four-digit seven-segment driver.
- Accepts an unsigned binary value over a valid/ready handshake and converts it with iterative shift-add-3 (double dabble), one bit per cycle.
- Holds the 16-bit packed BCD result and a 4-bit decimal-point pattern stable, ready for direct connection to the driver's data and dots inputs.
- Out-of-range values saturate to 9999 with all decimal points lit.

---
 rtl/bin2bcd_disp_pkg.sv | 14 +
 rtl/bin2bcd_disp_digit_adj.sv | 14 +
 rtl/bin2bcd_disp.sv | 120 ++++++++++++
 tb/tb_bin2bcd_disp.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_disp_pkg.sv
// Shared definitions for the binary-to-BCD display front end.
package bin2bcd_disp_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int          BCD_DIGITS = 4;
  localparam int unsigned MAX_VALUE  = 9999;
  localparam logic [15:0] OVF_DATA   = 16'h9999;
  localparam logic [3:0]  OVF_DOTS   = 4'b1111;

endpackage : bin2bcd_disp_pkg

// File: rtl/bin2bcd_disp_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added so
// that the following left shift carries correctly into the next digit.
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  // Add 3 when the digit is >= 5; 4-bit result, no carry out.
  always_comb begin
    adj = digit;
    if (digit >= 4'd5) adj = digit + 4'd3;
  end

endmodule : bcd_digit_adj

// File: rtl/bin2bcd_disp.sv
// Sequential binary-to-BCD converter (one bit per cycle) whose result and
// decimal-point pattern are held stable for a four-digit seven-segment driver.
//
// Handshake: a transfer happens on a rising clk_in edge where valid_in and
// ready_out are both high; ready_out is high only in IDLE, and valid_in is
// ignored at every other time. bin_in/dp_in are sampled on that edge only.
module bin2bcd_disp
  import bin2bcd_disp_pkg::*;
#(
  parameter int BIN_WIDTH = 14
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic [BIN_WIDTH-1:0] bin_in,
  input  logic [3:0]           dp_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  output logic [15:0]          data_out,
  output logic [3:0]           dots_out,
  output logic                 done_out,
  output state_t               state_dbg
);

  localparam int CNT_W = (BIN_WIDTH > 2) ? $clog2(BIN_WIDTH) : 1;

  state_t               state, state_next;
  logic [BIN_WIDTH-1:0] bin_sr;
  logic [15:0]          bcd_sr;
  logic [15:0]          bcd_adj;
  logic [15:0]          bcd_shift;
  logic [BIN_WIDTH-1:0] bin_shift;
  logic [CNT_W-1:0]     cnt;
  logic [3:0]           dp_q;
  logic                 ovf_q;
  logic                 ovf_in;
  logic                 load;
  logic                 finish;

  // Constant false when BIN_WIDTH < 14, since bin_in can never exceed 9999.
  assign ovf_in = 32'(bin_in) > 32'(MAX_VALUE);

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (bcd_sr[g*4 +: 4]),
      .adj   (bcd_adj[g*4 +: 4])
    );
  end

  // The binary MSB enters the BCD LSB on every shift.
  assign bcd_shift = {bcd_adj[14:0], bin_sr[BIN_WIDTH-1]};
  assign bin_shift = {bin_sr[BIN_WIDTH-2:0], 1'b0};

  assign ready_out = (state == ST_IDLE);
  assign state_dbg = state;

  // State register.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) state <= ST_IDLE;
    else           state <= state_next;
  end

  // Next-state decode plus the load/finish strobes for the datapath.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (valid_in) begin
          load       = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt == '0) begin
          finish     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Working registers: capture on accept, shift-add-3 while converting.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      bin_sr <= '0;
      bcd_sr <= '0;
      cnt    <= '0;
      dp_q   <= '0;
      ovf_q  <= 1'b0;
    end else if (load) begin
      bin_sr <= bin_in;
      bcd_sr <= '0;
      dp_q   <= dp_in;
      ovf_q  <= ovf_in;
      cnt    <= CNT_W'(BIN_WIDTH - 1);
    end else if (state == ST_SHIFT) begin
      bin_sr <= bin_shift;
      bcd_sr <= bcd_shift;
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

  // Display outputs change only on the completion edge, never mid-conversion.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      data_out <= '0;
      dots_out <= '0;
      done_out <= 1'b0;
    end else begin
      done_out <= finish;
      if (finish) begin
        data_out <= ovf_q ? OVF_DATA : bcd_shift;
        dots_out <= ovf_q ? OVF_DOTS : dp_q;
      end
    end
  end

endmodule : bin2bcd_disp

// File: tb/tb_bin2bcd_disp.sv
// Directed bench for bin2bcd_disp (14-bit instance plus an 8-bit instance).
module tb_bin2bcd_disp;
  import bin2bcd_disp_pkg::*;

  localparam int W  = 14;
  localparam int W8 = 8;

  // Clock / reset
  logic clk_in = 1'b0;
  logic reset_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // DUT (14-bit)
  logic [W-1:0] bin_in = '0;
  logic [3:0]   dp_in = '0;
  logic         valid_in = 1'b0;
  logic         ready_out;
  logic [15:0]  data_out;
  logic [3:0]   dots_out;
  logic         done_out;
  state_t       state_dbg;

  bin2bcd_disp #(.BIN_WIDTH(W)) dut (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .bin_in    (bin_in),
    .dp_in     (dp_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .dots_out  (dots_out),
    .done_out  (done_out),
    .state_dbg (state_dbg)
  );

  // DUT (8-bit)
  logic [W8-1:0] bin8 = '0;
  logic [3:0]    dp8 = '0;
  logic          valid8 = 1'b0;
  logic          ready8;
  logic [15:0]   data8;
  logic [3:0]    dots8;
  logic          done8;
  state_t        state8;

  bin2bcd_disp #(.BIN_WIDTH(W8)) dut8 (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .bin_in    (bin8),
    .dp_in     (dp8),
    .valid_in  (valid8),
    .ready_out (ready8),
    .data_out  (data8),
    .dots_out  (dots8),
    .done_out  (done8),
    .state_dbg (state8)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    if (v > 9999) return 16'h9999;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready_out && n < 40) begin
      step();
      n++;
    end
    check({tag, "_ready_wait"}, 32'(ready_out), 32'd1);
  endtask

  // One full conversion with latency, stability, result and done-pulse checks.
  // When disturb is set, bin_in/valid_in are scrambled during SHIFT.
  task automatic convert(input int v, input logic [3:0] dp, input bit disturb, input string tag);
    logic [15:0] prev_data;
    logic [3:0]  prev_dots;
    int          lat;
    bit          ready_ok;
    bit          stable_ok;
    wait_ready(tag);
    prev_data = data_out;
    prev_dots = dots_out;
    bin_in    = W'(v);
    dp_in     = dp;
    valid_in  = 1'b1;
    step();
    valid_in  = 1'b0;
    lat       = 1;
    ready_ok  = 1'b1;
    stable_ok = 1'b1;
    while (lat < 40) begin
      if (ready_out) ready_ok = 1'b0;
      if (done_out || data_out !== prev_data || dots_out !== prev_dots) stable_ok = 1'b0;
      if (disturb) begin
        bin_in   = W'($urandom_range(0, 16383));
        dp_in    = 4'($urandom_range(0, 15));
        valid_in = 1'($urandom_range(0, 1));
      end
      step();
      if (done_out) break;
      lat++;
    end
    valid_in = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(W));
    check({tag, "_busy_ready_low"}, 32'(ready_ok), 32'd1);
    check({tag, "_output_stable"}, 32'(stable_ok), 32'd1);
    check({tag, "_data"}, 32'(data_out), 32'(ref_bcd(v)));
    check({tag, "_dots"}, 32'(dots_out), (v > 9999) ? 32'hF : 32'(dp));
    check({tag, "_ready_after"}, 32'(ready_out), 32'd1);
    step();
    check({tag, "_done_one_cycle"}, 32'(done_out), 32'd0);
  endtask

  initial begin : stim
    int n;
    bit no_done;
    bit stable_ok;

    // Reset state
    #2;
    check("rst_ready", 32'(ready_out), 32'd1);
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_dots", 32'(dots_out), 32'h0);
    check("rst_done", 32'(done_out), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    #20;
    reset_in = 1'b1;
    step();

    // Basic conversions and boundaries
    convert(1234, 4'b0100, 1'b0, "v1234");
    convert(0, 4'b0001, 1'b0, "v0");
    convert(9999, 4'b1010, 1'b0, "v9999");
    convert(10000, 4'b0000, 1'b0, "v10000");
    convert(16383, 4'b0010, 1'b0, "v16383");
    convert(5, 4'b1000, 1'b0, "v5");

    // Valid held high: 42 then 7, accepts 15 cycles apart
    wait_ready("hold");
    bin_in = W'(42);
    dp_in = 4'b0011;
    valid_in = 1'b1;
    step();
    bin_in = W'(7);
    dp_in = 4'b0110;
    n = 1;
    stable_ok = 1'b1;
    while (!done_out && n < 40) begin
      if (data_out !== 16'h0005) stable_ok = 1'b0;
      step();
      if (!done_out) n++;
    end
    check("hold_first_latency", 32'(n), 32'(W));
    check("hold_first_data", 32'(data_out), 32'h0042);
    check("hold_first_dots", 32'(dots_out), 32'h3);
    step();
    check("hold_second_accept", 32'(ready_out), 32'd0);
    check("hold_done_drop", 32'(done_out), 32'd0);
    valid_in = 1'b0;
    n = 1;
    while (!done_out && n < 40) begin
      if (data_out !== 16'h0042) stable_ok = 1'b0;
      step();
      if (!done_out) n++;
    end
    check("hold_second_latency", 32'(n), 32'(W));
    check("hold_second_data", 32'(data_out), 32'h0007);
    check("hold_second_dots", 32'(dots_out), 32'h6);
    check("hold_stable", 32'(stable_ok), 32'd1);
    step();

    // Inputs scrambled during SHIFT are ignored
    convert(2718, 4'b0101, 1'b1, "disturb2718");
    convert(10500, 4'b0001, 1'b1, "disturb10500");

    // Reset in the middle of a 5678 conversion
    wait_ready("rst_mid");
    bin_in = W'(5678);
    dp_in = 4'b1001;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    repeat (4) step();
    check("mid_busy", 32'(ready_out), 32'd0);
    #2;
    reset_in = 1'b0;
    #1;
    check("mid_rst_data", 32'(data_out), 32'h0);
    check("mid_rst_dots", 32'(dots_out), 32'h0);
    check("mid_rst_ready", 32'(ready_out), 32'd1);
    check("mid_rst_done", 32'(done_out), 32'd0);
    #10;
    reset_in = 1'b1;
    no_done = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done_out) no_done = 1'b0;
    end
    check("mid_no_done", 32'(no_done), 32'd1);
    check("mid_ready_after", 32'(ready_out), 32'd1);
    check("mid_data_after", 32'(data_out), 32'h0);

    // Strided sweep with boundaries against the decimal reference
    for (int v = 0; v <= 9999; v += 397) convert(v, 4'(v), 1'b0, "sweep");
    convert(9998, 4'b0111, 1'b0, "v9998");
    convert(1000, 4'b1100, 1'b0, "v1000");

    // 8-bit instance: 255 in 8 cycles
    bin8 = 8'd255;
    dp8 = 4'b0010;
    valid8 = 1'b1;
    check("w8_ready", 32'(ready8), 32'd1);
    step();
    valid8 = 1'b0;
    n = 1;
    while (!done8 && n < 40) begin
      step();
      if (!done8) n++;
    end
    check("w8_latency", 32'(n), 32'(W8));
    check("w8_data", 32'(data8), 32'h0255);
    check("w8_dots", 32'(dots8), 32'h2);
    step();
    check("w8_done_drop", 32'(done8), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_bin2bcd_disp
